sram_access_ctrl: RTL and testbench

- Initiator side of the dual-port FPGA SRAM: turns a single valid/ready request stream into SRAM port-0 writes (csb0/wmask0/addr0/din0) and port-1 reads (csb1/addr1), and captures dout1.
- Returns read data through a RESP_DEPTH-entry response buffer with its own valid/ready handshake.
- Sits between a core's load/store or instruction-fetch path and one SRAM instance.
- Drives all SRAM inputs from flops on posedge clk, which matches the SRAM's posedge input registers and negedge array access.

---
 rtl/sram_access_ctrl_if.sv | 23 ++
 rtl/sram_access_ctrl.sv | 122 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// Request/response handshake bundle between a core-side initiator and the SRAM access controller.
interface sram_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Initiator for a dual-port SRAM: port 0 writes, port 1 reads, with a small
// in-order response FIFO whose free space throttles request acceptance.
module sram_access_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_access_ctrl_if.slave     bus,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_oor;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_unused;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [CW:0]           w_used;

  logic                  r_vld_p1;
  logic                  r_oor_p1;
  logic                  r_vld_p2;
  logic                  r_oor_p2;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH:0]   r_buf [RESP_DEPTH];

  assign w_word   = bus.req_addr[ADDR_WIDTH+1:2];
  assign w_oor    = |bus.req_addr[31:ADDR_WIDTH+2];
  assign w_unused = &{1'b0, bus.req_addr[1:0]};

  // Reads still in the tag pipeline already own a FIFO slot.
  assign w_used   = (CW+1)'(r_count) + (CW+1)'(r_vld_p1) + (CW+1)'(r_vld_p2);
  assign w_ready  = !rst && (w_used < (CW+1)'(RESP_DEPTH));
  assign w_accept = bus.req_valid && w_ready;
  assign bus.req_ready = w_ready;

  // Stage p0 -> p1: launch the SRAM access from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_csb0   <= 1'b1;
      sram_csb1   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      sram_addr1  <= '0;
    end else begin
      sram_csb0 <= 1'b1;
      sram_csb1 <= 1'b1;
      if (w_accept && bus.req_we) begin
        sram_csb0   <= w_oor || (bus.req_wstrb == '0);
        sram_wmask0 <= bus.req_wstrb;
        sram_addr0  <= w_word;
        sram_din0   <= bus.req_wdata;
      end
      if (w_accept && !bus.req_we) begin
        sram_csb1  <= w_oor;
        sram_addr1 <= w_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept && !bus.req_we;
      r_vld_p2 <= r_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_oor_p1 <= w_oor;
    r_oor_p2 <= r_oor_p1;
  end

  // Stage p2: dout1 is valid here; capture into the response FIFO.
  assign w_push  = r_vld_p2;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wptr] <= {(r_oor_p2 ? {DATA_WIDTH{1'b0}} : sram_dout1), r_oor_p2};
  end

  assign bus.rsp_valid = w_valid;
  assign bus.rsp_rdata = w_valid ? r_buf[r_rptr][DATA_WIDTH:1] : '0;
  assign bus.rsp_err   = w_valid ? r_buf[r_rptr][0] : 1'b0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_push |-> (r_count < CW'(RESP_DEPTH)));

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: behavioural SRAM, transaction-level scoreboard and directed scenarios.
module tb_sram_access_ctrl;
  localparam int AW    = 11;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_csb0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout1 = '0;

  sram_access_ctrl_if bus();

  sram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_WMASKS(4), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
    .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural SRAM: posedge input registers, negedge array access.
  logic [31:0]   sram_mem [2048];
  logic          s_csb0 = 1'b1, s_csb1 = 1'b1;
  logic [3:0]    s_m0;
  logic [AW-1:0] s_a0, s_a1;
  logic [31:0]   s_d0;

  always @(posedge clk) begin
    s_csb0 <= sram_csb0;
    s_m0   <= sram_wmask0;
    s_a0   <= sram_addr0;
    s_d0   <= sram_din0;
    s_csb1 <= sram_csb1;
    s_a1   <= sram_addr1;
  end

  always @(negedge clk) begin
    if (s_csb0 === 1'b0)
      for (int b = 0; b < 4; b++)
        if (s_m0[b]) sram_mem[s_a0][8*b +: 8] <= s_d0[8*b +: 8];
    if (s_csb1 === 1'b0) sram_dout1 <= sram_mem[s_a1];
  end

  // Transaction-level reference: memory image plus ordered list of owed responses.
  typedef struct { logic [31:0] d; logic e; int due; } rsp_t;
  rsp_t          q[$];
  logic [31:0]   refmem [2048];
  int            cyc = 0;
  bit            model_on = 0;
  logic          exp_csb0 = 1'b1, exp_csb1 = 1'b1;
  logic [AW-1:0] exp_a0, exp_a1;
  logic [31:0]   exp_d0;
  logic [3:0]    exp_m0;
  int            n_reads = 0, n_disc = 0, dut_pops = 0;
  logic          ev, erdy, moor;
  logic [AW-1:0] mw;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      sram_mem[i] = '0;
      refmem[i]   = '0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    ev   = (q.size() > 0) && (q[0].due <= cyc);
    erdy = !rst && (q.size() < DEPTH);
    if (model_on) begin
      chk("req_ready", {31'b0, bus.req_ready}, {31'b0, erdy});
      chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, ev});
      chk("rsp_rdata", bus.rsp_rdata, ev ? q[0].d : 32'h0);
      chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, ev ? q[0].e : 1'b0});
      chk("csb0", {31'b0, sram_csb0}, {31'b0, exp_csb0});
      chk("csb1", {31'b0, sram_csb1}, {31'b0, exp_csb1});
      if (!exp_csb0) begin
        chk("addr0", {21'b0, sram_addr0}, {21'b0, exp_a0});
        chk("din0", sram_din0, exp_d0);
        chk("wmask0", {28'b0, sram_wmask0}, {28'b0, exp_m0});
      end
      if (!exp_csb1) chk("addr1", {21'b0, sram_addr1}, {21'b0, exp_a1});
      if (bus.rsp_valid && bus.rsp_ready) dut_pops++;
    end
    exp_csb0 = 1'b1;
    exp_csb1 = 1'b1;
    if (rst) begin
      n_disc  += q.size();
      q.delete();
      model_on = 1;
    end else if (model_on) begin
      if (ev && bus.rsp_ready) void'(q.pop_front());
      if (bus.req_valid && erdy) begin
        moor = |bus.req_addr[31:AW+2];
        mw   = bus.req_addr[AW+1:2];
        if (bus.req_we) begin
          if (!moor && bus.req_wstrb != 4'h0) begin
            exp_csb0 = 1'b0;
            exp_a0   = mw;
            exp_d0   = bus.req_wdata;
            exp_m0   = bus.req_wstrb;
            for (int b = 0; b < 4; b++)
              if (bus.req_wstrb[b]) refmem[mw][8*b +: 8] = bus.req_wdata[8*b +: 8];
          end
        end else begin
          n_reads++;
          q.push_back('{d: moor ? 32'h0 : refmem[mw], e: moor, due: cyc + 3});
          if (!moor) begin
            exp_csb1 = 1'b0;
            exp_a1   = mw;
          end
        end
      end
    end
  end

  // Present a request and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit done;
    done = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept_timeout: addr 0x%08h not accepted within 50 cycles", a);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b1;

    rst = 1'b1;
    step(2);
    chk("rst_csb0", {31'b0, sram_csb0}, 32'h1);
    chk("rst_csb1", {31'b0, sram_csb1}, 32'h1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
    chk("rst_addr0", {21'b0, sram_addr0}, 32'h0);
    chk("rst_din0", sram_din0, 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, bus.req_ready}, 32'h1);

    // Write then read same word, back to back.
    do_req(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    chk("wr_csb0_low", {31'b0, sram_csb0}, 32'h0);
    chk("wr_addr0", {21'b0, sram_addr0}, 32'h40);
    chk("wr_din0", sram_din0, 32'hDEADBEEF);
    do_req(1'b0, 32'h100, 32'h0, 4'h0);
    chk("wr_csb0_one_cycle", {31'b0, sram_csb0}, 32'h1);
    chk("rd_csb1_low", {31'b0, sram_csb1}, 32'h0);
    chk("rd_addr1", {21'b0, sram_addr1}, 32'h40);
    step(1);
    chk("rd_lat1_no_valid", {31'b0, bus.rsp_valid}, 32'h0);
    step(1);
    chk("rd_lat2_valid", {31'b0, bus.rsp_valid}, 32'h1);
    chk("rd_data", bus.rsp_rdata, 32'hDEADBEEF);
    chk("rd_err", {31'b0, bus.rsp_err}, 32'h0);

    // Byte-masked write.
    do_req(1'b1, 32'h100, 32'h11223344, 4'hF);
    do_req(1'b1, 32'h100, 32'hAABBCCDD, 4'h5);
    do_req(1'b0, 32'h100, 32'h0, 4'h0);
    step(2);
    chk("mask_data", bus.rsp_rdata, 32'h11BB33DD);

    // Backpressure.
    do_req(1'b1, 32'h0, 32'h10101010, 4'hF);
    do_req(1'b1, 32'h4, 32'h20202020, 4'hF);
    do_req(1'b1, 32'h8, 32'h30303030, 4'hF);
    do_req(1'b1, 32'hC, 32'h40404040, 4'hF);
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 32'h0, 32'h0, 4'h0);
    do_req(1'b0, 32'h4, 32'h0, 4'h0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h8;
    step(4);
    chk("bp_ready_low", {31'b0, bus.req_ready}, 32'h0);
    chk("bp_head_valid", {31'b0, bus.rsp_valid}, 32'h1);
    chk("bp_head_data", bus.rsp_rdata, 32'h10101010);
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 32'h8, 32'h0, 4'h0);
    do_req(1'b0, 32'hC, 32'h0, 4'h0);
    step(6);

    // Out-of-range accesses.
    do_req(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    chk("oor_rd_csb1", {31'b0, sram_csb1}, 32'h1);
    step(2);
    chk("oor_rd_valid", {31'b0, bus.rsp_valid}, 32'h1);
    chk("oor_rd_err", {31'b0, bus.rsp_err}, 32'h1);
    chk("oor_rd_data", bus.rsp_rdata, 32'h0);
    do_req(1'b1, 32'h0000_2000, 32'hFFFFFFFF, 4'hF);
    chk("oor_wr_csb0", {31'b0, sram_csb0}, 32'h1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0);
    step(2);
    chk("oor_wr_mem_unchanged", bus.rsp_rdata, 32'h10101010);
    step(2);

    // Reset while a read is in flight.
    do_req(1'b0, 32'h4, 32'h0, 4'h0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_csb0", {31'b0, sram_csb0}, 32'h1);
    chk("midrst_csb1", {31'b0, sram_csb1}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("midrst_no_rsp", {31'b0, bus.rsp_valid}, 32'h0);
      step(1);
    end

    // Mixed traffic after reset.
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    do_req(1'b0, 32'h20, 32'h0, 4'h0);
    do_req(1'b1, 32'h24, 32'h12345678, 4'h3);
    do_req(1'b0, 32'h24, 32'h0, 4'h0);
    do_req(1'b0, 32'h8, 32'h0, 4'h0);
    step(6);

    chk("rsp_count", dut_pops, n_reads - n_disc);
    chk("model_drained", q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
